// File: rtl/int_ctrl_pkg.sv
// Shared FSM encoding and CPU register map for the interrupt priority controller.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_SERVICE = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_ACK_ID  = 2'd1;
    localparam logic [1:0] ADDR_EOI     = 2'd2;
    localparam logic [1:0] ADDR_PENDING = 2'd3;

endpackage

// File: rtl/int_prio_arb.sv
// Combinational winner select: first set request scanning upward from a
// start index with wrap-around. Fixed priority is the same scan from 0.
module int_prio_arb #(
    parameter int NSRC     = 8,
    parameter int IDW      = 3,
    parameter int ARB_MODE = 0
) (
    input  logic [NSRC-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  win_id,
    output logic            any
);

    logic found;

    // Scan NSRC positions from the start index; the first hit wins.
    always_comb begin
        int start;
        win_id = '0;
        found  = 1'b0;
        start  = (ARB_MODE == 1) ? int'(rr_ptr) : 0;
        for (int i = 0; i < NSRC; i++) begin
            int idx;
            idx = start + i;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
        any = found;
    end

endmodule

// File: rtl/int_prio_ctrl.sv
// Interrupt controller: masks latched sources, picks one, raises irq_o,
// then runs the ack / EOI handshake and pulses a clear to the serviced source.
module int_prio_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NSRC     = 8,
    parameter int IDW      = 3,
    parameter int ARB_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src_pend_i,
    input  logic            cpuren_i,
    input  logic            cpuwen_i,
    input  logic [1:0]      cpuaddr_i,
    input  logic [NSRC-1:0] cpudi_i,
    output logic [NSRC-1:0] cpudo_o,
    output logic            irq_o,
    output logic [NSRC-1:0] src_clr_o
);

    state_t          state, state_nxt;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] req;
    logic [IDW-1:0]  active_id, active_nxt;
    logic [IDW-1:0]  rr_ptr, rr_nxt;
    logic [IDW-1:0]  win_id;
    logic            win_any;
    logic            ack_rd, eoi_wr, en_wr;

    assign req    = src_pend_i & enable;
    assign ack_rd = cpuren_i && (cpuaddr_i == ADDR_ACK_ID);
    assign eoi_wr = cpuwen_i && (cpuaddr_i == ADDR_EOI);
    assign en_wr  = cpuwen_i && (cpuaddr_i == ADDR_ENABLE);

    int_prio_arb #(
        .NSRC     (NSRC),
        .IDW      (IDW),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win_id (win_id),
        .any    (win_any)
    );

    // Next-state, winner capture and round-robin pointer advance.
    always_comb begin
        state_nxt  = state;
        active_nxt = active_id;
        rr_nxt     = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (req != '0) state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (win_any) begin
                    active_nxt = win_id;
                    state_nxt  = ST_ASSERT;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                // An ack in the same cycle the source drops still wins: the
                // CPU has already seen a valid ID on that read.
                if (ack_rd) begin
                    state_nxt = ST_SERVICE;
                    if (ARB_MODE == 1)
                        rr_nxt = (active_id == IDW'(NSRC - 1)) ? '0 : active_id + 1'b1;
                end else if (!req[active_id]) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, mask and registered outputs; irq and clear follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            enable    <= '0;
            active_id <= '0;
            rr_ptr    <= '0;
            irq_o     <= 1'b0;
            src_clr_o <= '0;
        end else begin
            state     <= state_nxt;
            active_id <= active_nxt;
            rr_ptr    <= rr_nxt;
            if (en_wr) enable <= cpudi_i;
            irq_o     <= (state_nxt == ST_ASSERT);
            src_clr_o <= (state_nxt == ST_CLEAR) ? (NSRC'(1) << active_id) : '0;
        end
    end

    // CPU read mux; zero whenever no read is in progress.
    always_comb begin
        cpudo_o = '0;
        if (cpuren_i) begin
            case (cpuaddr_i)
                ADDR_ENABLE:  cpudo_o = enable;
                ADDR_ACK_ID: begin
                    if (state inside {ST_ASSERT, ST_SERVICE, ST_CLEAR}) begin
                        cpudo_o[NSRC-1]  = 1'b1;
                        cpudo_o[IDW-1:0] = active_id;
                    end
                end
                ADDR_PENDING: cpudo_o = src_pend_i;
                default:      cpudo_o = '0;
            endcase
        end
    end

endmodule
